// File: rtl/pipeline_controller.sv
// pipeline_controller: stall/flush/halt sequencer for the 5-stage MIPS pipeline.
// It drives the pipeline-register enables, the IF/ID flush and the ID/EX bubble.
// It also drains the pipeline after a HALT and handles debug single-step.
// Optional feature: define STALL_COUNTER_EN to add the saturating o_stall_count output.
module pipeline_controller #(
    parameter int DRAIN_CYCLES = 3,
    parameter int NB_DRAIN     = 2,
    parameter int NB_STATE     = 3
`ifdef STALL_COUNTER_EN
    ,
    parameter int NB_COUNT     = 32
`endif
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic                i_hazard,
    input  logic                i_branch_taken,
    input  logic                i_halt,
    input  logic                i_step_mode,
    input  logic                i_step,
    output logic                o_pc_en,
    output logic                o_if_id_en,
    output logic                o_id_ex_en,
    output logic                o_ex_mem_en,
    output logic                o_mem_wb_en,
    output logic                o_if_id_flush,
    output logic                o_id_ex_bubble,
    output logic                o_halted,
    output logic [NB_STATE-1:0] o_state
`ifdef STALL_COUNTER_EN
    ,
    output logic [NB_COUNT-1:0] o_stall_count
`endif
);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        DRAIN     = 3'd1,
        HALTED    = 3'd2,
        STEP_WAIT = 3'd3,
        STEP_RUN  = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic [NB_DRAIN-1:0] cnt_reg, cnt_next;
    logic                halt_accept;

    // State and drain counter; frozen while the debug unit withholds i_valid.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
        end else if (i_valid) begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state and enable decode; everything stays idle under reset or without i_valid.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        o_pc_en        = 1'b0;
        o_if_id_en     = 1'b0;
        o_id_ex_en     = 1'b0;
        o_ex_mem_en    = 1'b0;
        o_mem_wb_en    = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_bubble = 1'b0;
        // A HALT held in ID by a stall is not accepted until the stall clears.
        halt_accept    = i_halt && !i_hazard;
        if (!i_reset && i_valid) begin
            unique case (state_reg)
                RUN, STEP_RUN: begin
                    o_pc_en     = 1'b1;
                    o_if_id_en  = 1'b1;
                    o_id_ex_en  = 1'b1;
                    o_ex_mem_en = 1'b1;
                    o_mem_wb_en = 1'b1;
                    if (i_hazard) begin
                        // Hold IF and ID; the branch is re-evaluated, so no flush.
                        o_pc_en        = 1'b0;
                        o_if_id_en     = 1'b0;
                        o_id_ex_bubble = 1'b1;
                    end else if (i_branch_taken) begin
                        o_if_id_flush = 1'b1;
                    end
                    if (halt_accept) begin
                        state_next = DRAIN;
                        cnt_next   = NB_DRAIN'(DRAIN_CYCLES - 1);
                    end else if (state_reg == STEP_RUN || i_step_mode) begin
                        state_next = STEP_WAIT;
                    end
                end
                STEP_WAIT: begin
                    if (i_step) begin
                        state_next = STEP_RUN;
                    end else if (!i_step_mode) begin
                        state_next = RUN;
                    end
                end
                DRAIN: begin
                    o_id_ex_en     = 1'b1;
                    o_ex_mem_en    = 1'b1;
                    o_mem_wb_en    = 1'b1;
                    o_id_ex_bubble = 1'b1;
                    if (cnt_reg == '0) begin
                        state_next = HALTED;
                    end else begin
                        cnt_next = cnt_reg - NB_DRAIN'(1);
                    end
                end
                HALTED: begin
                    state_next = HALTED;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    assign o_halted = (state_reg == HALTED) && !i_reset;
    assign o_state  = NB_STATE'(state_reg);

`ifdef STALL_COUNTER_EN
    logic [NB_COUNT-1:0] stall_count_reg;
    logic                stall_cycle;

    assign stall_cycle = i_valid && !o_pc_en &&
                         (state_reg == RUN || state_reg == STEP_RUN || state_reg == DRAIN);

    // Saturating count of cycles in which the PC was held while the pipeline was live.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            stall_count_reg <= '0;
        end else if (stall_cycle && !(&stall_count_reg)) begin
            stall_count_reg <= stall_count_reg + NB_COUNT'(1);
        end
    end

    assign o_stall_count = stall_count_reg;
`endif

endmodule
